b1_rx: RTL and testbench

Receiving-end decoder for the 4-bit b1 code word ({po3,po2,po1,po0}) produced by the b1 encoder. It accepts code words over a valid/ready handshake and checks each one for legality. Legal words are decoded back to the 3-bit source value ({pi2,pi1,pi0}) and buffered in a small FIFO; illegal words are dropped and counted. It sits between a b1-encoded link and the downstream consumer of the original 3-bit symbols.

---
 rtl/b1_rx.sv | 123 ++++++++++++
 tb/tb_b1_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/b1_rx.sv
// b1 code-word receiver: checks each 4-bit word for legality, decodes legal words
// into a small FIFO of {ambig, data} and counts dropped illegal words.
module b1_rx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     code_valid,
    input  logic [3:0]               code,
    output logic                     code_ready,
    output logic                     dec_valid,
    output logic [2:0]               dec_data,
    output logic                     dec_ambig,
    input  logic                     dec_ready,
    output logic [$clog2(DEPTH):0]   dec_level,
    input  logic                     clear_err,
    output logic [CNT_W-1:0]         err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Returns {legal, ambig, pi2, pi1, pi0}; ambiguous words take pi1/pi0 from history.
    function automatic logic [4:0] b1_decode(input logic [3:0] cw, input logic h);
        logic       legal;
        logic       amb;
        logic [2:0] d;
        legal = (cw[0] != cw[3]) && !(cw[1] && cw[2]);
        d[2]  = cw[0];
        if (cw[1]) begin
            d[1] = ~h;
            d[0] = h;
            amb  = 1'b1;
        end else begin
            d[1] = cw[2] ? ~cw[0] : cw[0];
            d[0] = d[1];
            amb  = 1'b0;
        end
        return {legal, amb, d};
    endfunction

    logic [3:0]       mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             hist_r;
    logic [CNT_W-1:0] err_r;
    logic             code_ready_r, dec_valid_r;
    logic [3:0]       head_r;

    logic [4:0]       dec_s;
    logic             acc_s, push_s, pop_s, bad_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [LW-1:0]    level_nxt_s;
    logic [3:0]       head_nxt_s;
    logic [CNT_W-1:0] err_nxt_s;

    // Decode, handshake and next-state for pointers, occupancy, head and error count.
    always_comb begin
        dec_s        = b1_decode(code, hist_r);
        acc_s        = code_valid & code_ready_r;
        push_s       = acc_s & dec_s[4];
        bad_s        = acc_s & ~dec_s[4];
        pop_s        = dec_valid_r & dec_ready;
        rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
        level_nxt_s  = level_r + LW'(push_s) - LW'(pop_s);
        head_nxt_s   = 4'b0000;
        err_nxt_s    = err_r;
        // The new word becomes the head when it lands where the read pointer will point.
        if (level_nxt_s == {LW{1'b0}}) begin
            head_nxt_s = 4'b0000;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = dec_s[3:0];
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
        if (clear_err) begin
            err_nxt_s = bad_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
        end else if (bad_s && (err_r != {CNT_W{1'b1}})) begin
            err_nxt_s = err_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_nxt_s = err_r;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy level.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= dec_s[3:0];
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            level_r      <= {LW{1'b0}};
            hist_r       <= 1'b0;
            err_r        <= {CNT_W{1'b0}};
            code_ready_r <= 1'b1;
            dec_valid_r  <= 1'b0;
            head_r       <= 4'b0000;
        end else begin
            wr_ptr_r     <= wr_ptr_r + AW'(push_s);
            rd_ptr_r     <= rd_ptr_nxt_s;
            level_r      <= level_nxt_s;
            hist_r       <= push_s ? dec_s[0] : hist_r;
            err_r        <= err_nxt_s;
            code_ready_r <= (level_nxt_s != LW'(DEPTH));
            dec_valid_r  <= (level_nxt_s != {LW{1'b0}});
            head_r       <= head_nxt_s;
        end
    end

    assign code_ready = code_ready_r;
    assign dec_valid  = dec_valid_r;
    assign dec_ambig  = head_r[3];
    assign dec_data   = head_r[2:0];
    assign dec_level  = level_r;
    assign err_count  = err_r;

endmodule

// File: tb/tb_b1_rx.sv
// Directed, table-driven bench for b1_rx with hand-computed expectations,
// plus sequences for saturation, push/pop at level 2 and asynchronous reset.
module tb_b1_rx;

    logic       clock;
    logic       rst_n;
    logic       code_valid, dec_ready, clear_err;
    logic [3:0] code;
    logic       code_ready, dec_valid, dec_ambig;
    logic [2:0] dec_data;
    logic [2:0] dec_level;
    logic [7:0] err_count;

    logic       s_code_valid, s_dec_ready, s_clear_err;
    logic [3:0] s_code;
    logic       s_code_ready, s_dec_valid, s_dec_ambig;
    logic [2:0] s_dec_data;
    logic [2:0] s_dec_level;
    logic [1:0] s_err_count;

    int total = 0;
    int bad   = 0;

    b1_rx #(.DEPTH(4), .CNT_W(8)) u_dut (
        .clock(clock), .rst_n(rst_n), .code_valid(code_valid), .code(code),
        .code_ready(code_ready), .dec_valid(dec_valid), .dec_data(dec_data),
        .dec_ambig(dec_ambig), .dec_ready(dec_ready), .dec_level(dec_level),
        .clear_err(clear_err), .err_count(err_count)
    );

    b1_rx #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clock(clock), .rst_n(rst_n), .code_valid(s_code_valid), .code(s_code),
        .code_ready(s_code_ready), .dec_valid(s_dec_valid), .dec_data(s_dec_data),
        .dec_ambig(s_dec_ambig), .dec_ready(s_dec_ready), .dec_level(s_dec_level),
        .clear_err(s_clear_err), .err_count(s_err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       cv;
        logic [3:0] code;
        logic       dr;
        logic       clr;
        int         lvl;
        logic       vld;
        logic [2:0] data;
        logic       amb;
        int         err;
        logic       rdy;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic cv, input logic [3:0] c, input logic dr, input logic clr);
        code_valid = cv;
        code       = c;
        dec_ready  = dr;
        clear_err  = clr;
        @(posedge clock);
        #1;
    endtask

    logic [3:0] pp_code [4];
    logic [2:0] pp_exp  [4];
    logic [2:0] q [$];
    logic [1:0] sat_exp;

    initial begin
        // cv, code, dr, clr | level, valid, data, ambig, err, ready
        tbl[0]  = '{1'b1, 4'b1000, 1'b1, 1'b0, 1, 1'b1, 3'b000, 1'b0, 0, 1'b1};
        tbl[1]  = '{1'b1, 4'b1100, 1'b1, 1'b0, 1, 1'b1, 3'b011, 1'b0, 0, 1'b1};
        tbl[2]  = '{1'b1, 4'b0011, 1'b1, 1'b0, 1, 1'b1, 3'b101, 1'b1, 0, 1'b1};
        tbl[3]  = '{1'b1, 4'b0011, 1'b1, 1'b0, 1, 1'b1, 3'b101, 1'b1, 0, 1'b1};
        tbl[4]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 3'b000, 1'b0, 1, 1'b1};
        tbl[5]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 0, 1'b0, 3'b000, 1'b0, 2, 1'b1};
        tbl[6]  = '{1'b1, 4'b1110, 1'b0, 1'b0, 0, 1'b0, 3'b000, 1'b0, 3, 1'b1};
        tbl[7]  = '{1'b1, 4'b0011, 1'b0, 1'b0, 1, 1'b1, 3'b101, 1'b1, 3, 1'b1};
        tbl[8]  = '{1'b1, 4'b0110, 1'b0, 1'b1, 1, 1'b1, 3'b101, 1'b1, 1, 1'b1};
        tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1, 1'b1, 3'b101, 1'b1, 0, 1'b1};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 3'b000, 1'b0, 0, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 3'b000, 1'b0, 0, 1'b1};
        tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 3'b000, 1'b0, 0, 1'b1};
        tbl[13] = '{1'b1, 4'b0001, 1'b0, 1'b0, 1, 1'b1, 3'b111, 1'b0, 0, 1'b1};
        tbl[14] = '{1'b1, 4'b0101, 1'b0, 1'b0, 2, 1'b1, 3'b111, 1'b0, 0, 1'b1};
        tbl[15] = '{1'b1, 4'b1000, 1'b0, 1'b0, 3, 1'b1, 3'b111, 1'b0, 0, 1'b1};
        tbl[16] = '{1'b1, 4'b1100, 1'b0, 1'b0, 4, 1'b1, 3'b111, 1'b0, 0, 1'b0};
        tbl[17] = '{1'b1, 4'b1010, 1'b0, 1'b0, 4, 1'b1, 3'b111, 1'b0, 0, 1'b0};
        tbl[18] = '{1'b1, 4'b1010, 1'b0, 1'b0, 4, 1'b1, 3'b111, 1'b0, 0, 1'b0};
        tbl[19] = '{1'b1, 4'b1010, 1'b1, 1'b0, 3, 1'b1, 3'b100, 1'b0, 0, 1'b1};
        tbl[20] = '{1'b1, 4'b1010, 1'b0, 1'b0, 4, 1'b1, 3'b100, 1'b0, 0, 1'b0};
        tbl[21] = '{1'b0, 4'b0000, 1'b1, 1'b0, 3, 1'b1, 3'b000, 1'b0, 0, 1'b1};
        tbl[22] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2, 1'b1, 3'b011, 1'b0, 0, 1'b1};
        tbl[23] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1, 1'b1, 3'b001, 1'b1, 0, 1'b1};
        tbl[24] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 3'b000, 1'b0, 0, 1'b1};

        pp_code[0] = 4'b1000; pp_exp[0] = 3'b000;
        pp_code[1] = 4'b1100; pp_exp[1] = 3'b011;
        pp_code[2] = 4'b0001; pp_exp[2] = 3'b111;
        pp_code[3] = 4'b0101; pp_exp[3] = 3'b100;

        rst_n = 1'b0;
        code_valid = 1'b0; code = 4'b0000; dec_ready = 1'b0; clear_err = 1'b0;
        s_code_valid = 1'b0; s_code = 4'b0000; s_dec_ready = 1'b1; s_clear_err = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_level", dec_level, 0);
        chk("rst_valid", dec_valid, 0);
        chk("rst_data",  dec_data, 0);
        chk("rst_err",   err_count, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", code_ready, 1);

        // Saturating counter on the narrow instance, then clear together with an illegal word.
        for (int i = 0; i < 5; i++) begin
            s_code_valid = 1'b1;
            s_code = 4'b0000;
            @(posedge clock);
            #1;
            sat_exp = (i >= 2) ? 2'd3 : 2'(i + 1);
            chk("sat_err", s_err_count, sat_exp);
        end
        s_clear_err = 1'b1;
        @(posedge clock);
        #1;
        chk("sat_clr_err", s_err_count, 1);
        chk("sat_level", s_dec_level, 0);
        s_clear_err = 1'b0;
        s_code_valid = 1'b0;

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].cv, tbl[i].code, tbl[i].dr, tbl[i].clr);
            chk($sformatf("v%0d_level", i), dec_level, tbl[i].lvl);
            chk($sformatf("v%0d_valid", i), dec_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk($sformatf("v%0d_data", i), dec_data, tbl[i].data);
                chk($sformatf("v%0d_ambig", i), dec_ambig, tbl[i].amb);
            end
            chk($sformatf("v%0d_err", i), err_count, tbl[i].err);
            chk($sformatf("v%0d_ready", i), code_ready, tbl[i].rdy);
        end

        // Simultaneous push and pop at level 2.
        step(1'b1, pp_code[0], 1'b0, 1'b0);
        q.push_back(pp_exp[0]);
        step(1'b1, pp_code[1], 1'b0, 1'b0);
        q.push_back(pp_exp[1]);
        chk("pp_start_level", dec_level, 2);
        for (int i = 2; i < 12; i++) begin
            step(1'b1, pp_code[i % 4], 1'b1, 1'b0);
            void'(q.pop_front());
            q.push_back(pp_exp[i % 4]);
            chk($sformatf("pp%0d_level", i), dec_level, 2);
            chk($sformatf("pp%0d_data", i), dec_data, q[0]);
        end
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        chk("pp_drain_level", dec_level, 0);

        // Asynchronous reset with FIFO at level 3 and two errors counted.
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        step(1'b1, 4'b1100, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        code_valid = 1'b0;
        chk("pre_rst_level", dec_level, 3);
        chk("pre_rst_err", err_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", dec_level, 0);
        chk("arst_valid", dec_valid, 0);
        chk("arst_data", dec_data, 0);
        chk("arst_ambig", dec_ambig, 0);
        chk("arst_err", err_count, 0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        #1;
        chk("arst_ready", code_ready, 1);
        step(1'b1, 4'b0011, 1'b0, 1'b0);
        chk("post_rst_data", dec_data, 3'b110);
        chk("post_rst_ambig", dec_ambig, 1);
        chk("post_rst_level", dec_level, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
